// File: rtl/udcnt_pkg.sv
// Shared definitions for the up/down counter: direction encodings, the
// wrap/saturate mode type and a parameter-legality check used at elaboration.
package udcnt_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } udcnt_mode_e;

    // True when the width, highest count and reset value form a usable set:
    // width of at least 2, MAX_COUNT in 1..2**width-1, RESET_VAL <= MAX_COUNT.
    function automatic bit udcnt_params_ok(input int width,
                                           input longint unsigned max_count,
                                           input longint unsigned reset_val);
        longint unsigned limit;
        if (width < 2 || width > 63) begin
            return 1'b0;
        end
        limit = (64'd1 << width) - 64'd1;
        return (max_count >= 64'd1) && (max_count <= limit) && (reset_val <= max_count);
    endfunction

endpackage : udcnt_pkg

// File: rtl/udcnt_next_val.sv
// Combinational next-count and terminal-count qualification for one enabled
// count step. The increment is formed one bit wider than the counter so a
// modulus below 2**WIDTH is detected by compare, never by silent overflow.
// With UDCNT_SAT_EN defined a mode input selects wrap or clamp at the limits;
// without it the counter always wraps and no clamp logic exists.
module udcnt_next_val
    import udcnt_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_COUNT = '1
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             up_down_i,
`ifdef UDCNT_SAT_EN
    input  udcnt_mode_e      mode_i,
`endif
    output logic [WIDTH-1:0] next_o,
    output logic             tc_o
);

    localparam logic [WIDTH:0]   MAX_EXT = {1'b0, MAX_COUNT};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH:0] up_wide;

    assign up_wide = {1'b0, q_i} + {1'b0, ONE};

    // Step up or down; at a limit either wrap or clamp, flagging tc either way.
    always_comb begin
        next_o = q_i;
        tc_o   = 1'b0;
        if (up_down_i == DIR_UP) begin
            if (up_wide > MAX_EXT) begin
                tc_o = 1'b1;
`ifdef UDCNT_SAT_EN
                next_o = (mode_i == MODE_SAT) ? MAX_COUNT : '0;
`else
                next_o = '0;
`endif
            end else begin
                next_o = up_wide[WIDTH-1:0];
            end
        end else begin
            if (q_i == '0) begin
                tc_o = 1'b1;
`ifdef UDCNT_SAT_EN
                next_o = (mode_i == MODE_SAT) ? '0 : MAX_COUNT;
`else
                next_o = MAX_COUNT;
`endif
            end else begin
                next_o = q_i - ONE;
            end
        end
    end

endmodule : udcnt_next_val

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with programmable modulus, clamped parallel
// load, count enable and a registered terminal-count pulse.
// Optional feature macro: UDCNT_SAT_EN adds the sat_mode port and run-time
// selectable saturation at the limits; when undefined the counter wraps.
module updown_counter_mod
    import udcnt_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned RESET_VAL = 64'd0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             up_down,
`ifdef UDCNT_SAT_EN
    input  logic             sat_mode,
`endif
    output logic [WIDTH-1:0] q_out,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    generate
        if (!udcnt_params_ok(WIDTH, MAX_COUNT, RESET_VAL)) begin : g_param_error
            $error("updown_counter_mod: illegal WIDTH/MAX_COUNT/RESET_VAL combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_V   = MAX_COUNT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESET_V = RESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] step_val;
    logic             step_tc;
    logic [WIDTH-1:0] load_val;

    udcnt_next_val #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_V)
    ) u_next (
        .q_i       (count_q),
        .up_down_i (up_down),
`ifdef UDCNT_SAT_EN
        .mode_i    (sat_mode ? MODE_SAT : MODE_WRAP),
`endif
        .next_o    (step_val),
        .tc_o      (step_tc)
    );

    // Out-of-range load values are clamped so the count never leaves 0..MAX.
    assign load_val = (data_in > MAX_V) ? MAX_V : data_in;

    // Load beats count beats hold; only an enabled count step can raise tc.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load_en) begin
            count_d = load_val;
        end else if (en) begin
            count_d = step_val;
            tc_d    = step_tc;
        end
    end

    // Count and terminal-count registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= RESET_V;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign q_out  = count_q;
    assign tc     = tc_q;
    assign at_max = (count_q == MAX_V);
    assign at_min = (count_q == '0);

endmodule : updown_counter_mod

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod (WIDTH=4, MAX_COUNT=9, RESET_VAL=3).
module tb_updown_counter_mod;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en = 1'b0;
    logic         load_en = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         up_down = 1'b1;
    logic         sat_mode = 1'b0;
    logic [W-1:0] q_out;
    logic         tc, at_max, at_min;

    int tests_run = 0;
    int tests_failed = 0;

    updown_counter_mod #(
        .WIDTH     (W),
        .MAX_COUNT (64'd9),
        .RESET_VAL (64'd3)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .load_en  (load_en),
        .data_in  (data_in),
        .up_down  (up_down),
`ifdef UDCNT_SAT_EN
        .sat_mode (sat_mode),
`endif
        .q_out    (q_out),
        .tc       (tc),
        .at_max   (at_max),
        .at_min   (at_min)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n;
        logic         ld;
        logic         cen;
        logic         up;
        logic [W-1:0] din;
        logic [W-1:0] exp_q;
        logic         exp_tc;
        logic         exp_max;
        logic         exp_min;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst_n, input logic ld, input logic cen,
                                input logic up, input int din, input int eq,
                                input logic etc);
        vec_t v;
        v.rst_n   = rst_n;
        v.ld      = ld;
        v.cen     = cen;
        v.up      = up;
        v.din     = W'(din);
        v.exp_q   = W'(eq);
        v.exp_tc  = etc;
        v.exp_max = (eq == 9);
        v.exp_min = (eq == 0);
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic [W-1:0] eq,
                             input logic etc);
        chk({tag, ".q_out"},  idx, int'(q_out),  int'(eq));
        chk({tag, ".tc"},     idx, int'(tc),     int'(etc));
        chk({tag, ".at_max"}, idx, int'(at_max), int'(eq == 4'd9));
        chk({tag, ".at_min"}, idx, int'(at_min), int'(eq == 4'd0));
        $display("[TB] %s step %0d: q_out=%0d tc=%0d at_max=%0d at_min=%0d", tag, idx,
                 q_out, tc, at_max, at_min);
    endtask

    // Drive on the falling edge, let the rising edge happen, sample 1 time unit later.
    task automatic step(input logic rst_n, input logic ld, input logic cen,
                        input logic up, input logic [W-1:0] din);
        @(negedge clk);
        reset_n = rst_n;
        load_en = ld;
        en      = cen;
        up_down = up;
        data_in = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset, two edges
        add(0, 0, 0, 1, 0, 3, 0);
        add(0, 0, 0, 1, 0, 3, 0);
        // start from 0, decade count up with wrap
        add(1, 1, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 9; i++) add(1, 0, 1, 1, 0, i, 0);
        add(1, 0, 1, 1, 0, 0, 1);
        add(1, 0, 0, 1, 0, 0, 0);
        // wrap down from 0
        add(1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 9, 1);
        add(1, 0, 0, 0, 0, 9, 0);
        // load priority over count, clamp of 14 to 9, then plain load
        add(1, 1, 1, 1, 14, 9, 0);
        add(1, 1, 0, 1, 5, 5, 0);
        add(1, 0, 1, 1, 0, 6, 0);
        add(1, 0, 1, 1, 0, 7, 0);
        // reset together with load and count
        add(0, 1, 1, 1, 8, 3, 0);
        // direction change takes effect at once
        add(1, 0, 1, 0, 0, 2, 0);
        add(1, 0, 1, 1, 0, 3, 0);
        add(1, 0, 1, 0, 0, 2, 0);
        add(1, 0, 1, 0, 0, 1, 0);
        add(1, 0, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 9, 1);
        add(1, 0, 1, 0, 0, 8, 0);

        sat_mode = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].ld, vecs[i].cen, vecs[i].up, vecs[i].din);
            check_all("vec", i, vecs[i].exp_q, vecs[i].exp_tc);
        end

        // tc is registered: it stays high through the cycle even if en drops
        step(1, 1, 0, 1, 4'd9);
        check_all("tc_reg", 0, 4'd9, 1'b0);
        step(1, 0, 1, 1, 4'd0);
        check_all("tc_reg", 1, 4'd0, 1'b1);
        @(negedge clk);
        en = 1'b0;
        #2;
        check_all("tc_reg", 2, 4'd0, 1'b1);
        @(posedge clk);
        #1;
        check_all("tc_reg", 3, 4'd0, 1'b0);

`ifdef UDCNT_SAT_EN
        // saturation at the top: tc held high while blocked, drops on hold
        sat_mode = 1'b1;
        step(1, 1, 0, 1, 4'd9);
        check_all("sat", 0, 4'd9, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step(1, 0, 1, 1, 4'd0);
            check_all("sat", i, 4'd9, 1'b1);
        end
        step(1, 0, 0, 1, 4'd0);
        check_all("sat", 4, 4'd9, 1'b0);
        // saturation at the bottom
        step(1, 1, 0, 0, 4'd1);
        check_all("sat", 5, 4'd1, 1'b0);
        step(1, 0, 1, 0, 4'd0);
        check_all("sat", 6, 4'd0, 1'b0);
        step(1, 0, 1, 0, 4'd0);
        check_all("sat", 7, 4'd0, 1'b1);
        step(1, 0, 1, 0, 4'd0);
        check_all("sat", 8, 4'd0, 1'b1);
        // back to wrap mode at run time
        sat_mode = 1'b0;
        step(1, 0, 1, 0, 4'd0);
        check_all("sat", 9, 4'd9, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_updown_counter_mod

// File: doc/updown_counter_mod.md
# updown_counter_mod

Parametrised synchronous up/down counter with a programmable modulus, parallel load, count enable and a registered terminal-count pulse. It generalises the 3-bit load/up/down counter to arbitrary width and modulus, for use as a timebase, decade/BCD digit or cascadable stage in the counter library. It optionally clamps at the range limits instead of wrapping.

## Interface
- WIDTH, 8: counter width in bits, ≥ 2.
- MAX_COUNT, 2**WIDTH-1: highest count value, so the modulus is MAX_COUNT+1. Range 1 to 2**WIDTH-1.
- RESET_VAL, 0: value loaded on reset. Must be ≤ MAX_COUNT.

Ports (reset reset_n, synchronous, active-low; clock clk):
- clk  in  1  clock; all state changes on its rising edge.
- reset_n  in  1  synchronous active-low reset.
- en  in  1  count enable.
- load_en  in  1  parallel load strobe.
- data_in  in  WIDTH  load value.
- up_down  in  1  1 = count up, 0 = count down.
- sat_mode  in  1  1 = saturate at the limits, 0 = wrap (present only with UDCNT_SAT_EN).
- q_out  out  WIDTH  current count.
- tc  out  1  registered terminal-count pulse.
- at_max  out  1  high when q_out == MAX_COUNT.
- at_min  out  1  high when q_out == 0.

## Operation
- Priority per edge: reset, then load, then count, then hold.
- Reset: q_out=RESET_VAL and tc=0. at_max and at_min follow from RESET_VAL.
- Load (load_en=1): q_out takes data_in, clamped to MAX_COUNT if data_in > MAX_COUNT.
  - Load ignores en and never asserts tc.
- Count (en=1, load_en=0):
  - Up: q_out+1.
  - Down: q_out-1.
- Hold (en=0, load_en=0): q_out unchanged and tc=0.
- Wrap mode:
  - Up at MAX_COUNT goes to 0.
  - Down at 0 goes to MAX_COUNT.
  - tc=1 on the edge where the wrap occurs.
- Saturate mode:
  - Up at MAX_COUNT holds MAX_COUNT.
  - Down at 0 holds 0.
  - tc=1 on every enabled edge where the count is blocked at a limit.
- tc is a registered pulse: high for exactly the one cycle following the qualifying edge, unless the next edge qualifies again (continuous saturation keeps tc high).
- Arithmetic:
  - Internal next-value computed at WIDTH+1 bits; no silent modulo-2**WIDTH overflow when MAX_COUNT < 2**WIDTH-1.
  - An out-of-range q_out is impossible by construction.
- at_max and at_min are combinational decodes of q_out. They are never X after reset.
- up_down and sat_mode are sampled on the same edge as en; a direction change takes effect immediately.
- Reset asserted mid-count overrides load and count on that edge.

## Timing
- Latency: q_out updates on the same edge en or load_en is sampled; 1-cycle input-to-output latency.
- tc changes on the same edge as the wrap/saturation it reports; it is not combinational from en.
- Cascading: the tc of stage N drives the en of stage N+1. The next stage therefore advances one cycle after the wrap, which is an accepted and documented skew.
- No handshake; inputs must be stable around the clk edge only.

## Configuration
- UDCNT_SAT_EN defined:
  - The sat_mode port exists.
  - Saturate behaviour is selectable at run time.
- UDCNT_SAT_EN undefined:
  - The sat_mode port is absent.
  - The counter always wraps.
  - Clamp logic is not synthesised.

## Structure
- Package udcnt_pkg:
  - Direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0.
  - A mode typedef (MODE_WRAP, MODE_SAT).
  - A function checking parameter legality; the top module elaborates an error on an illegal parameter set.
- Sub-module udcnt_next_val: combinational next-count and tc-qualify logic, parameterised by WIDTH and MAX_COUNT.
- The top module holds the registers, the load clamp and the at_max/at_min decodes.

## Test plan
- Reset: WIDTH=4, MAX_COUNT=9, RESET_VAL=3; hold reset_n=0 for 2 edges.
  - Required: q_out=3, tc=0, at_min=0, at_max=0.
- Decade wrap up: from 0, en=1, up_down=1 for 10 edges.
  - Required: q_out goes 1…9, then 0.
  - Required: tc=1 only in the cycle after the 9→0 edge.
- Wrap down: load 0, then count down 1 edge.
  - Required: q_out=9, tc=1 for one cycle.
- Load priority and clamp: load_en=1, en=1, data_in=4'd14.
  - Required: q_out=9, tc=0.
  - Then load 5 with en=0: q_out=5, no count on that edge.
- Saturate (UDCNT_SAT_EN): at 9 with sat_mode=1, count up 3 edges.
  - Required: q_out stays 9, tc high for 3 cycles.
  - Then en=0: tc drops to 0.
- Mid-count reset: count up from 6 and assert reset_n=0 together with load_en=1.
  - Required: q_out=RESET_VAL and tc=0 on that edge.
